// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with redirect latching.
// Redirect priority is exception > latched target > branch > sequential step.
// A redirect that arrives while the fetch stage is stalled is latched (HOLD)
// and applied on the first edge on which the stage accepts a new PC.
// Optional feature macro: PC_ALIGN_CHECK_EN adds a registered misalignment
// flag (pc_adel). When the macro is absent, pc_adel is tied low.
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h8000_0000),
    parameter int unsigned       STEP      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ds_allowin,
    input  logic              pc_stop,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    output logic              pc_to_ds_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              redirect_pending,
    output logic              pc_adel
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef enum logic {
        KIND_BR  = 1'b0,
        KIND_EXC = 1'b1
    } kind_t;

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    state_t            r_state;
    kind_t             r_pend_kind;
    logic [ADDR_W-1:0] r_pend_target;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;

    logic              w_ready_go;
    logic              w_allowin;
    logic [ADDR_W-1:0] w_next_pc;

    assign w_ready_go = !pc_stop;
    assign w_allowin  = !r_pc_valid || (w_ready_go && ds_allowin);

    // Select the next PC by redirect priority; the adder wraps naturally.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path
        // leaves it unassigned and a latch is inferred.
        w_next_pc = r_pc + STEP_V;
        if (exc_valid) begin
            w_next_pc = exc_target;
        end else if (r_state == ST_HOLD) begin
            w_next_pc = r_pend_target;
        end else if (br_valid) begin
            w_next_pc = br_target;
        end
    end

    // PC register plus RUN/HOLD redirect latch.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update from the same pre-edge values.
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_VEC;
            r_pc_valid    <= 1'b1;
            r_pend_target <= '0;
            r_pend_kind   <= KIND_BR;
        end else if (w_allowin) begin
            r_pc       <= w_next_pc;
            r_pc_valid <= 1'b1;
            r_state    <= ST_RUN;
        end else if (exc_valid) begin
            // An exception always takes the latch, whatever is held.
            r_state       <= ST_HOLD;
            r_pend_target <= exc_target;
            r_pend_kind   <= KIND_EXC;
        end else if (br_valid && (r_state == ST_RUN || r_pend_kind == KIND_BR)) begin
            // A branch may replace another branch but never an exception.
            r_state       <= ST_HOLD;
            r_pend_target <= br_target;
            r_pend_kind   <= KIND_BR;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_pc_adel;

    // Misalignment flag loaded in step with the PC it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_adel <= 1'b0;
        end else if (w_allowin) begin
            r_pc_adel <= (w_next_pc[1:0] != 2'b00);
        end
    end

    assign pc_adel = r_pc_adel;
`else
    assign pc_adel = 1'b0;
`endif

    assign pc_out           = r_pc;
    assign pc_to_ds_valid   = r_pc_valid && w_ready_go;
    assign redirect_pending = (r_state == ST_HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the PC sequencing rules.
module tb_pc_gen;

    localparam logic [31:0] RST_VEC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        ds_allowin;
    logic        pc_stop;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        pc_to_ds_valid;
    logic [31:0] pc_out;
    logic        redirect_pending;
    logic        pc_adel;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the fetch PC and an optional pending redirect.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic        m_pend_exc;

    pc_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ds_allowin       (ds_allowin),
        .pc_stop          (pc_stop),
        .br_valid         (br_valid),
        .br_target        (br_target),
        .exc_valid        (exc_valid),
        .exc_target       (exc_target),
        .pc_to_ds_valid   (pc_to_ds_valid),
        .pc_out           (pc_out),
        .redirect_pending (redirect_pending),
        .pc_adel          (pc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_adel(input logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
        return pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc       = RST_VEC;
        m_pend     = 1'b0;
        m_pend_tgt = '0;
        m_pend_exc = 1'b0;
    endtask

    // Drive one cycle of inputs, check outputs before the edge, then advance
    // the model and the clock together.
    task automatic step(input logic ds, input logic stop,
                        input logic bv, input logic [31:0] bt,
                        input logic ev, input logic [31:0] et);
        ds_allowin = ds;
        pc_stop    = stop;
        br_valid   = bv;
        br_target  = bt;
        exc_valid  = ev;
        exc_target = et;
        #1;
        check("pc_out", pc_out, m_pc);
        check("pc_to_ds_valid", 32'(pc_to_ds_valid), 32'(!stop));
        check("redirect_pending", 32'(redirect_pending), 32'(m_pend));
        check("pc_adel", 32'(pc_adel), 32'(exp_adel(m_pc)));
        if (!stop && ds) begin
            if (ev)          m_pc = et;
            else if (m_pend) m_pc = m_pend_tgt;
            else if (bv)     m_pc = bt;
            else             m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end else if (ev) begin
            m_pend = 1'b1; m_pend_tgt = et; m_pend_exc = 1'b1;
        end else if (bv && !(m_pend && m_pend_exc)) begin
            m_pend = 1'b1; m_pend_tgt = bt; m_pend_exc = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        ds_allowin = 1'b1; pc_stop = 1'b0;
        br_valid = 1'b0; br_target = '0; exc_valid = 1'b0; exc_target = '0;
        model_reset();
        #12;
        check("reset pc_out", pc_out, RST_VEC);
        check("reset pending", 32'(redirect_pending), 32'd0);
        check("reset pc_adel", 32'(pc_adel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from the reset vector up to 80000010.
        run(4);
        check("seq reaches 80000010", pc_out, 32'h8000_0010);
        // Stall three cycles, then resume.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        run(1);
        check("resume after stop", pc_out, 32'h8000_0014);

        // Branch while the fetch stage is stalled, applied next cycle.
        step(1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, '0);
        check("branch latched", 32'(redirect_pending), 32'd1);
        run(1);
        check("latched branch applied", pc_out, 32'h8000_1000);

        // Simultaneous branch and exception: exception wins; a later branch
        // cannot displace a latched exception.
        step(1'b1, 1'b0, 1'b1, 32'h8000_2000, 1'b1, 32'hBFC0_0380);
        check("exc beats br", pc_out, 32'hBFC0_0380);
        step(1'b0, 1'b0, 1'b1, 32'h8000_2000, 1'b1, 32'hBFC0_0380);
        step(1'b0, 1'b0, 1'b1, 32'h8000_3000, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h8000_4000, 1'b0, '0);
        run(1);
        check("held exc kept", pc_out, 32'hBFC0_0380);

        // Branch replaces branch while held; fresh exception on release wins.
        step(1'b0, 1'b0, 1'b1, 32'h1000_0000, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 32'h2000_0000, 1'b0, '0);
        run(2);
        check("newer br wins", pc_out, 32'h2000_0004);
        step(1'b0, 1'b0, 1'b1, 32'h3000_0000, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hBFC0_0000);
        run(1);

        // Wrap-around at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
        run(2);
        check("pc wraps", pc_out, 32'h0000_0004);

        // Misaligned branch target advances normally.
        step(1'b1, 1'b0, 1'b1, 32'h8000_0002, 1'b0, '0);
        run(2);

        // Asynchronous reset in the middle of HOLD discards the latch.
        step(1'b0, 1'b0, 1'b1, 32'h8000_5000, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset pc", pc_out, RST_VEC);
        check("async reset pending", 32'(redirect_pending), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] bt, et;
            bt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            et = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFFC;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, bt,
                 $urandom_range(0, 9) == 0, et);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 32'h8000_0000: PC value loaded at reset.
REQ-003 Parameter STEP, default 4: sequential increment in bytes.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ds_allowin  in  1  fetch stage can accept a PC this cycle.
REQ-008 pc_stop  in  1  hold current PC; stage not ready to go.
REQ-009 br_valid  in  1  branch redirect request, single-cycle pulse.
REQ-010 br_target  in  ADDR_W  branch target.
REQ-011 exc_valid  in  1  exception/ERET redirect request, single-cycle pulse.
REQ-012 exc_target  in  ADDR_W  exception target.
REQ-013 pc_to_ds_valid  out  1  pc_out is valid for the fetch stage.
REQ-014 pc_out  out  ADDR_W  current fetch PC (registered).
REQ-015 redirect_pending  out  1  a redirect is latched and not yet applied.
REQ-016 pc_adel  out  1  pc_out is misaligned (see Configuration).

Function
REQ-017 ready_go = !pc_stop; allowin = !pc_valid || (ready_go && ds_allowin).
REQ-018 pc_to_ds_valid = pc_valid && ready_go, combinational from registers and pc_stop.
REQ-019 next PC priority: exc_valid > latched pending target > br_valid > pc_out + STEP.
REQ-020 pc_out + STEP wraps modulo 2^ADDR_W; no carry out or flag.
REQ-021 On a rising edge with allowin=1: pc_out <= next PC, pc_valid <= 1, pending cleared.
REQ-022 On allowin=0, pc_out and pc_valid hold; no redirect is lost.
REQ-023 State machine: RUN (no pending) and HOLD (redirect latched).
REQ-024 RUN -> HOLD: br_valid or exc_valid while allowin=0; target latched with its kind (BR/EXC).
REQ-025 HOLD -> RUN: first edge with allowin=1; latched target, or a fresh exc_valid, loaded into pc_out.
REQ-026 In HOLD, new exc_valid overwrites any latched target; new br_valid overwrites only a latched BR, never EXC.
REQ-027 br_valid and exc_valid in the same cycle: exception wins, branch discarded.
REQ-028 redirect_pending = (state == HOLD).
REQ-029 Redirect latency: applied redirect appears on pc_out one cycle after the accepting edge.

Reset
REQ-030 On rst_n=0 (asynchronous): pc_out = RESET_VEC, pc_valid = 1, state = RUN, pending cleared, pc_adel = 0.
REQ-031 Reset mid-HOLD discards the latched target; first PC after release is RESET_VEC.
REQ-032 pc_to_ds_valid is 1 from the first cycle after reset release unless pc_stop=1.

Configuration
REQ-033 Macro PC_ALIGN_CHECK_EN: when defined, pc_adel = pc_valid && (pc_out mod 4 != 0), registered alongside pc_out.
REQ-034 With PC_ALIGN_CHECK_EN defined, a misaligned PC still advances normally; the fetch stage handles the exception.
REQ-035 Without PC_ALIGN_CHECK_EN, pc_adel is tied 0 and targets are used verbatim.

Verification
REQ-036 Release reset, ds_allowin=1, pc_stop=0 -> pc_out 80000000, 80000004, 80000008 on successive cycles, valid high.
REQ-037 pc_stop=1 for 3 cycles at 80000010 -> pc_out holds 80000010, pc_to_ds_valid=0, then resumes at 80000014.
REQ-038 ds_allowin=0, br_valid pulse with target 80001000 -> redirect_pending=1; ds_allowin=1 next cycle -> pc_out=80001000, pending=0.
REQ-039 Same cycle br_valid (80002000) and exc_valid (BFC00380) -> pc_out=BFC00380; later branch while holding EXC is ignored.
REQ-040 ADDR_W=32, pc_out=FFFFFFFC, no redirect -> pc_out=00000000 next cycle.
REQ-041 PC_ALIGN_CHECK_EN defined, br_target 80000002 -> pc_adel=1 with pc_out=80000002; undefined -> pc_adel stays 0.
